i2c_master: RTL and testbench
=============================

Name: i2c_master

Overview:
- Single-master I2C controller: the initiator counterpart to the team's I2C slave blocks.
- Converts a transaction command (7-bit address, R/W, byte count) into START, address byte, data bytes with ACK/NACK handling, and STOP on scl/sda.
- Sits between the SoC register/bus side and the board I2C pins.
- Write bytes are pulled through a tx_data/tx_req handshake; read bytes are pushed out through rx_data/rx_valid.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL period. 250 gives 100 kHz at 100 MHz. Legal range is 2..4095.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- scl  output  1  I2C clock, driven push-pull, single master
- sda  inout  1  I2C data, open-drain: drives 0 or 'z'
- start  input  1  one-cycle command strobe; ignored while busy=1
- addr  input  7  slave address, latched on accepted start
- rw  input  1  0 = write, 1 = read; latched on accepted start
- len  input  4  byte count 0..15; latched on accepted start
- tx_data  input  8  write byte, sampled in the cycle tx_req=1
- tx_req  output  1  one-cycle pulse: current tx_data consumed
- rx_data  output  8  last received byte; held until next rx_valid
- rx_valid  output  1  one-cycle pulse: rx_data updated
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when transaction finishes, with or without error
- ack_err  output  1  set on a NACK from the slave; cleared on the next accepted start

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, scl=1, sda released.
  - tx_req=rx_valid=done=busy=ack_err=0, rx_data=0.
  - Reset mid-transfer aborts immediately with no STOP generated.
- Timing base: a quarter tick every CLK_DIV clocks. Each bit cell is 4 quarters, 4*CLK_DIV clocks.
  - q0: scl=0, master updates the SDA drive.
  - q1: scl=1.
  - q2: scl=1; sda is sampled at q2 entry through a 2-FF synchroniser.
  - q3: scl=0.
  - The tick counter restarts on every state change.
- States:
  - IDLE: scl=1, sda released. On start=1: latch addr/rw/len, busy=1, ack_err=0, go to START.
  - START (1 cell): q0-q1 sda released with scl=1; q2 sda driven 0 with scl=1; q3 scl=0. Then go to ADDR.
  - ADDR: 8 cells shifting {addr,rw}, MSB first. Then go to ADDR_ACK.
  - ADDR_ACK: sda released, sample at q2.
    - Sampled 1: ack_err=1, go to STOP.
    - Otherwise: len=0 goes to STOP; rw=0 goes to WR_DATA; rw=1 goes to RD_DATA.
  - WR_DATA: tx_req pulses in the first cycle of the state and tx_data is latched into the shift register that cycle. Shift 8 bits MSB first, then go to WR_ACK.
  - WR_ACK: sample at q2.
    - NACK: ack_err=1, go to STOP.
    - ACK with remaining count >0: go to WR_DATA.
    - ACK with remaining count 0: go to STOP.
  - RD_DATA: sda released; shift sampled bits MSB first for 8 cells. At end: rx_data updates and rx_valid pulses, then go to RD_ACK.
  - RD_ACK: drive 0 (ACK) if bytes remain, release (NACK) on the last byte. Then go to RD_DATA or STOP.
  - STOP (1 cell): q0 sda=0 with scl=0; q1 scl=1; q2 sda released (STOP); q3 bus idle. At end of q3: done pulses, busy=0, go to IDLE.
- Byte counter: 4-bit, loaded with len and decremented after each data ACK cell.
- start asserted while busy=1 is dropped; no queuing.
- A master with sda released that samples 0 is not arbitration loss; there is a single master and no arbitration support.
- No clock stretching: scl is never read back.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP);
  - constants I2C_WRITE=1'b0 and I2C_READ=1'b1;
  - quarter phase constants Q0..Q3.
- One sub-module, i2c_tick_gen: a CLK_DIV divider with restart input that outputs the quarter tick and the 2-bit phase.

Test Plan:
- Bench uses CLK_DIV=4 and a behavioural open-drain slave at address 7'h07 with a pull-up.
- Write, addr=7'h07, len=2, tx_data 8'hA5 then 8'h3C:
  - bus shows START, byte 8'h0E, ACK, A5, ACK, 3C, ACK, STOP;
  - tx_req pulses exactly twice;
  - done pulses once; ack_err=0.
- Read, addr=7'h07, len=3, slave returns 8'h11, 8'h22, 8'h33:
  - rx_valid pulses 3 times with those values;
  - master ACKs bytes 1-2 and NACKs byte 3, then STOP.
- Address NACK, addr=7'h55 with no responder:
  - STOP follows the address ACK cell;
  - ack_err=1 and done pulses;
  - tx_req never pulses.
- len=0 probe to 7'h07: START, address, ACK, STOP; done pulses; no tx_req or rx_valid.
- Second start pulse during busy is ignored, and the following idle start is accepted with ack_err cleared.
- reset=0 in the middle of the second data byte: next cycle scl=1, sda released, busy=0, no done pulse.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-master I2C controller.
package i2c_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP
    } state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t Q0 = 2'd0;
    localparam phase_t Q1 = 2'd1;
    localparam phase_t Q2 = 2'd2;
    localparam phase_t Q3 = 2'd3;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_master_if.sv
// Command / data handshake between the SoC side and the I2C master.
interface i2c_master_if;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [3:0] len;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        input  start, addr, rw, len, tx_data,
        output tx_req, rx_data, rx_valid, busy, done, ack_err
    );

    modport slave (
        output start, addr, rw, len, tx_data,
        input  tx_req, rx_data, rx_valid, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: o_tick marks the last clk of each quarter, o_phase names it.
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_restart,
    output logic   o_tick,
    output phase_t o_phase
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    phase_t           r_phase;

    // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
    always_ff @(posedge clk) begin
        if (!reset || i_restart) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick  = (r_cnt == LAST);
    assign o_phase = r_phase;

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller: START, address, data bytes with ACK/NACK, STOP.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic          clk,
    input  logic          reset,
    output logic          scl,
    inout  wire           sda,
    i2c_master_if.master  bus
);
    state_t     r_state, w_state_next;
    phase_t     w_phase;
    logic       w_tick, w_cell_end, w_restart;
    logic       w_scl, w_sda_low;

    logic       r_sda_s1, r_sda_s2, r_sda_smp;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_byte_cnt;
    logic [6:0] r_addr;
    logic       r_rw;
    logic       r_busy, r_done, r_ack_err, r_tx_req, r_rx_valid;
    logic [7:0] r_rx_data;

    assign w_cell_end = w_tick && (w_phase == Q3);
    assign w_restart  = (w_state_next != r_state);

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .i_restart(w_restart),
        .o_tick   (w_tick),
        .o_phase  (w_phase)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:     if (bus.start) w_state_next = START;
            START:    if (w_cell_end) w_state_next = ADDR;
            ADDR:     if (w_cell_end && r_bit_cnt == 3'd7) w_state_next = ADDR_ACK;
            ADDR_ACK: if (w_cell_end) begin
                if (r_sda_smp || r_byte_cnt == 4'd0) w_state_next = STOP;
                else if (r_rw == I2C_READ)           w_state_next = RD_DATA;
                else                                 w_state_next = WR_DATA;
            end
            WR_DATA:  if (w_cell_end && r_bit_cnt == 3'd7) w_state_next = WR_ACK;
            WR_ACK:   if (w_cell_end) begin
                if (r_sda_smp || r_byte_cnt == 4'd1) w_state_next = STOP;
                else                                 w_state_next = WR_DATA;
            end
            RD_DATA:  if (w_cell_end && r_bit_cnt == 3'd7) w_state_next = RD_ACK;
            RD_ACK:   if (w_cell_end) w_state_next = (r_byte_cnt == 4'd1) ? STOP : RD_DATA;
            STOP:     if (w_cell_end) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        unique case (r_state)
            IDLE: ;
            START: begin
                w_scl     = (w_phase != Q3);
                w_sda_low = (w_phase == Q2) || (w_phase == Q3);
            end
            STOP: begin
                w_scl     = (w_phase != Q0);
                w_sda_low = (w_phase == Q0) || (w_phase == Q1);
            end
            default: begin
                w_scl = (w_phase == Q1) || (w_phase == Q2);
                if (r_state == ADDR)    w_sda_low = !r_shift[7];
                // The byte is loaded during the tx_req cycle, so drive straight from tx_data then
                if (r_state == WR_DATA) w_sda_low = r_tx_req ? !bus.tx_data[7] : !r_shift[7];
                if (r_state == RD_ACK)  w_sda_low = (r_byte_cnt > 4'd1);
            end
        endcase
    end

    assign scl = w_scl;
    assign sda = w_sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_smp  <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_sda_s1   <= sda;
            r_sda_s2   <= r_sda_s1;
            r_tx_req   <= (w_state_next == WR_DATA) && (r_state != WR_DATA);
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            if (w_restart)       r_bit_cnt <= '0;
            else if (w_cell_end) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_tick && w_phase == Q1) r_sda_smp <= r_sda_s2;
            unique case (r_state)
                IDLE: if (bus.start) begin
                    r_addr     <= bus.addr;
                    r_rw       <= bus.rw;
                    r_byte_cnt <= bus.len;
                    r_busy     <= 1'b1;
                    r_ack_err  <= 1'b0;
                end
                START:    if (w_cell_end) r_shift <= {r_addr, r_rw};
                ADDR:     if (w_cell_end) r_shift <= {r_shift[6:0], 1'b0};
                ADDR_ACK: if (w_cell_end && r_sda_smp) r_ack_err <= 1'b1;
                WR_DATA: begin
                    if (r_tx_req)        r_shift <= bus.tx_data;
                    else if (w_cell_end) r_shift <= {r_shift[6:0], 1'b0};
                end
                WR_ACK: if (w_cell_end) begin
                    if (r_sda_smp) r_ack_err  <= 1'b1;
                    else           r_byte_cnt <= r_byte_cnt - 4'd1;
                end
                RD_DATA: begin
                    if (w_tick && w_phase == Q1) r_shift <= {r_shift[6:0], r_sda_s2};
                    if (w_cell_end && r_bit_cnt == 3'd7) begin
                        r_rx_data  <= r_shift;
                        r_rx_valid <= 1'b1;
                    end
                end
                RD_ACK: if (w_cell_end) r_byte_cnt <= r_byte_cnt - 4'd1;
                STOP: if (w_cell_end) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_req   = r_tx_req;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.ack_err  = r_ack_err;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: open-drain slave model at 7'h07 plus bus and pulse monitors.
module tb_i2c_master;
    localparam int         CLK_DIV = 4;
    localparam logic [6:0] SL_ADDR = 7'h07;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic scl;
    wire  sda;

    pullup (sda);

    i2c_master_if bus_if ();

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk  (clk),
        .reset(reset),
        .scl  (scl),
        .sda  (sda),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-data source: tx_idx advances on the edge that consumes the current byte
    logic [7:0] tx_vec [16];
    logic [3:0] tx_idx = 4'd0;
    assign bus_if.tx_data = tx_vec[tx_idx];
    always @(posedge clk) if (bus_if.tx_req) tx_idx <= tx_idx + 4'd1;

    // Pulse monitors
    int         n_txreq = 0, n_done = 0;
    logic [7:0] rx_q [$];
    always @(negedge clk) begin
        if (bus_if.tx_req)   n_txreq++;
        if (bus_if.done)     n_done++;
        if (bus_if.rx_valid) rx_q.push_back(bus_if.rx_data);
    end

    // Open-drain slave model and bus monitor, sampled mid-cycle
    logic       sl_low = 1'b0;
    assign sda = sl_low ? 1'b0 : 1'bz;

    logic       prev_scl = 1'b1, prev_sda = 1'b1, sda_v;
    bit         in_frame, is_addr, matched, rd, rd_stop;
    int         bitn, rd_idx;
    logic [7:0] sh, rd_cur;
    logic [7:0] rd_bytes [3] = '{8'h11, 8'h22, 8'h33};
    int         n_start = 0, n_stop = 0;
    logic [7:0] mon_byte [$];
    logic       mon_ack  [$];

    always @(negedge clk) begin
        sda_v = (sda !== 1'b0);
        if (!reset) begin
            in_frame = 0;
            sl_low   = 1'b0;
        end else if (scl && prev_scl && prev_sda && !sda_v) begin
            in_frame = 1; bitn = -1; is_addr = 1; matched = 0;
            rd = 0; rd_stop = 0; rd_idx = 0; sl_low = 1'b0;
            n_start++;
        end else if (scl && prev_scl && !prev_sda && sda_v) begin
            if (in_frame) n_stop++;
            in_frame = 0;
            sl_low   = 1'b0;
        end else if (in_frame && scl && !prev_scl) begin
            if (bitn >= 0 && bitn < 8) sh = {sh[6:0], sda_v};
            else if (bitn == 8) begin
                mon_byte.push_back(sh);
                mon_ack.push_back(sda_v);
                if (!is_addr && rd && sda_v) rd_stop = 1;
            end
        end else if (in_frame && !scl && prev_scl) begin
            if (bitn == -1) begin
                bitn   = 0;
                sl_low = 1'b0;
            end else if (bitn < 7) begin
                bitn++;
                sl_low = (!is_addr && matched && rd) ? !rd_cur[3'(7 - bitn)] : 1'b0;
            end else if (bitn == 7) begin
                bitn = 8;
                if (is_addr) begin
                    matched = (sh[7:1] == SL_ADDR);
                    rd      = sh[0];
                    sl_low  = matched;
                end else begin
                    sl_low  = matched && !rd;
                end
            end else begin
                bitn    = 0;
                is_addr = 0;
                if (matched && rd && !rd_stop && rd_idx < 3) begin
                    rd_cur = rd_bytes[rd_idx];
                    rd_idx++;
                    sl_low = !rd_cur[7];
                end else begin
                    sl_low = 1'b0;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda_v;
    end

    int b_tx, b_done, b_start, b_stop, b_mon, b_rx;

    task automatic mark();
        b_tx = n_txreq; b_done = n_done; b_start = n_start;
        b_stop = n_stop; b_mon = mon_byte.size(); b_rx = rx_q.size();
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [3:0] n);
        mark();
        @(posedge clk); #1;
        bus_if.addr = a; bus_if.rw = r; bus_if.len = n; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (bus_if.done) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Bytes packed first-byte-in-MSB; acks bit i belongs to byte i
    task automatic check_frame(input string tag, input int nb, input logic [31:0] bytes,
                               input logic [3:0] acks);
        check({tag, "_nbytes"}, 32'(mon_byte.size() - b_mon), 32'(nb));
        for (int i = 0; i < nb; i++) begin
            check({tag, "_byte"}, 32'(mon_byte[b_mon + i]), 32'(bytes[31 - 8*i -: 8]));
            check({tag, "_ack"},  32'(mon_ack[b_mon + i]),  32'(acks[i]));
        end
        check({tag, "_starts"}, 32'(n_start - b_start), 32'd1);
        check({tag, "_stops"},  32'(n_stop - b_stop),   32'd1);
    endtask

    initial begin
        bus_if.start = 1'b0; bus_if.addr = '0; bus_if.rw = 1'b0; bus_if.len = '0;
        for (int i = 0; i < 16; i++) tx_vec[i] = 8'h00;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_scl",      32'(scl),              32'd1);
        check("rst_sda",      32'(sda),              32'd1);
        check("rst_busy",     32'(bus_if.busy),      32'd0);
        check("rst_done",     32'(bus_if.done),      32'd0);
        check("rst_ack_err",  32'(bus_if.ack_err),   32'd0);
        check("rst_rx_data",  32'(bus_if.rx_data),   32'd0);
        check("rst_tx_req",   32'(bus_if.tx_req),    32'd0);
        check("rst_rx_valid", 32'(bus_if.rx_valid),  32'd0);
        reset = 1'b1;
        repeat (4) @(posedge clk);

        // Write two bytes to 7'h07
        tx_vec[tx_idx]         = 8'hA5;
        tx_vec[tx_idx + 4'd1]  = 8'h3C;
        run_txn(SL_ADDR, i2c_pkg::I2C_WRITE, 4'd2);
        check("wr_busy", 32'(bus_if.busy), 32'd1);
        wait_done("wr");
        check_frame("wr", 3, 32'h0EA53C00, 4'b0000);
        check("wr_tx_req_cnt", 32'(n_txreq - b_tx),   32'd2);
        check("wr_done_cnt",   32'(n_done - b_done),  32'd1);
        check("wr_ack_err",    32'(bus_if.ack_err),   32'd0);
        check("wr_busy_end",   32'(bus_if.busy),      32'd0);

        // Read three bytes from 7'h07
        run_txn(SL_ADDR, i2c_pkg::I2C_READ, 4'd3);
        wait_done("rd");
        check_frame("rd", 4, 32'h0F112233, 4'b1000);
        check("rd_rx_cnt", 32'(rx_q.size() - b_rx), 32'd3);
        check("rd_rx0",    32'(rx_q[b_rx]),         32'h11);
        check("rd_rx1",    32'(rx_q[b_rx + 1]),     32'h22);
        check("rd_rx2",    32'(rx_q[b_rx + 2]),     32'h33);
        check("rd_rx_hold",    32'(bus_if.rx_data),  32'h33);
        check("rd_tx_req_cnt", 32'(n_txreq - b_tx),  32'd0);
        check("rd_done_cnt",   32'(n_done - b_done), 32'd1);
        check("rd_ack_err",    32'(bus_if.ack_err),  32'd0);

        // Address NACK: nobody at 7'h55
        run_txn(7'h55, i2c_pkg::I2C_WRITE, 4'd2);
        wait_done("nack");
        check_frame("nack", 1, 32'hAA000000, 4'b0001);
        check("nack_ack_err",    32'(bus_if.ack_err),  32'd1);
        check("nack_done_cnt",   32'(n_done - b_done), 32'd1);
        check("nack_tx_req_cnt", 32'(n_txreq - b_tx),  32'd0);

        // len=0 probe; a start while busy must be dropped; ack_err clears on acceptance
        run_txn(SL_ADDR, i2c_pkg::I2C_WRITE, 4'd0);
        check("probe_ack_err_clr", 32'(bus_if.ack_err), 32'd0);
        check("probe_busy",        32'(bus_if.busy),    32'd1);
        repeat (40) @(posedge clk);
        #1;
        bus_if.addr = 7'h55; bus_if.rw = 1'b1; bus_if.len = 4'd5; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        wait_done("probe");
        check_frame("probe", 1, 32'h0E000000, 4'b0000);
        check("probe_tx_req_cnt", 32'(n_txreq - b_tx),    32'd0);
        check("probe_rx_cnt",     32'(rx_q.size() - b_rx), 32'd0);
        check("probe_ack_err",    32'(bus_if.ack_err),    32'd0);
        repeat (200) @(posedge clk);
        #1;
        check("probe_no_requeue_busy",  32'(bus_if.busy),       32'd0);
        check("probe_no_requeue_start", 32'(n_start - b_start), 32'd1);
        check("probe_done_cnt",         32'(n_done - b_done),   32'd1);

        // Reset in the middle of the second data byte
        tx_vec[tx_idx]        = 8'h5A;
        tx_vec[tx_idx + 4'd1] = 8'hC3;
        run_txn(SL_ADDR, i2c_pkg::I2C_WRITE, 4'd2);
        begin
            bit got2 = 0;
            for (int k = 0; k < 3000 && !got2; k++) begin
                @(negedge clk);
                if (n_txreq - b_tx >= 2) got2 = 1;
            end
            check("abort_second_tx_req", 32'(got2), 32'd1);
        end
        repeat (3 * 4 * CLK_DIV) @(posedge clk);
        #1;
        check("abort_mid_busy", 32'(bus_if.busy), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_scl",  32'(scl),         32'd1);
        check("abort_sda",  32'(sda),         32'd1);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("abort_no_done", 32'(n_done - b_done), 32'd0);
        check("abort_idle",    32'(bus_if.busy),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
